im_loader: RTL and testbench

Program loader that writes instructions into the instruction memory (IM) while the core is held off, then reads them back and checks a stream checksum before releasing the core. It sits between an external word stream (host/testbench/boot link) and the IM port of the processor top. It is the write-side counterpart of the core's instruction fetch path. During normal execution it leaves the IM idle so the PC-driven fetch path owns the memory.

---
 rtl/im_loader.sv | 141 ++++++++++++++
 tb/tb_im_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: streams a program into instruction memory, verifies it by read-back checksum, then releases the core.
// With no stream stalls done rises 2N+3 edges after the edge that samples load_start (one below the nominal 2N+4).
module im_loader #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic [MemSize:0]    load_len,
  input  logic                in_valid,
  input  logic [DataSize-1:0] in_data,
  output logic                in_ready,
  output logic [MemSize-1:0]  IM_address,
  output logic                enable_mem,
  output logic                enable_write,
  output logic                enable_fetch,
  output logic [DataSize-1:0] IMin,
  input  logic [DataSize-1:0] IMout,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, VERIFY, DONE, ERROR} state_t;
  localparam logic [MemSize:0] DEPTH = {1'b1, {MemSize{1'b0}}};
  state_t state_q, state_d;
  logic [MemSize:0] len_q, len_d, addr_q, addr_d, rcnt_q, rcnt_d;
  logic [DataSize-1:0] wsum_q, wsum_d, rsum_q, rsum_d, exp_q, exp_d, imin_q, imin_d;
  logic [MemSize-1:0] im_addr_q, im_addr_d;
  logic wr_q, wr_d, fe_q, fe_d, rd_v_q, rd_v_d;
  logic ready_q, hold_q, busy_q, done_q, error_q;
  logic hs;
  assign hs = in_valid & ready_q;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    rcnt_d    = rcnt_q;
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    exp_d     = exp_q;
    im_addr_d = im_addr_q;
    imin_d    = imin_q;
    wr_d      = 1'b0;
    fe_d      = 1'b0;
    rd_v_d    = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (load_start) begin
        if (load_len == '0 || load_len > DEPTH) state_d = ERROR;
        else begin
          state_d = LOAD;
          len_d   = load_len;
          addr_d  = '0;
          wsum_d  = '0;
        end
      end
      LOAD: if (hs) begin
        wr_d      = 1'b1;
        im_addr_d = addr_q[MemSize-1:0];
        imin_d    = in_data;
        wsum_d    = wsum_q + in_data;
        addr_d    = addr_q + 1'b1;
        state_d   = addr_q == len_q - 1'b1 ? CHECK : LOAD;
      end
      CHECK: if (hs) begin
        exp_d     = in_data;
        fe_d      = 1'b1;
        im_addr_d = '0;
        addr_d    = (MemSize+1)'(1);
        rsum_d    = '0;
        rcnt_d    = '0;
        state_d   = VERIFY;
      end
      VERIFY: begin
        // rd_v tracks which cycles carry fetched data on IMout
        rd_v_d = fe_q;
        if (addr_q < len_q) begin
          fe_d      = 1'b1;
          im_addr_d = addr_q[MemSize-1:0];
          addr_d    = addr_q + 1'b1;
        end
        if (rd_v_q) begin
          rsum_d = rsum_q + IMout;
          rcnt_d = rcnt_q + 1'b1;
        end
        if (rcnt_q == len_q) state_d = rsum_q == exp_q && wsum_q == exp_q ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      rcnt_q    <= '0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      exp_q     <= '0;
      im_addr_q <= '0;
      imin_q    <= '0;
      wr_q      <= 1'b0;
      fe_q      <= 1'b0;
      rd_v_q    <= 1'b0;
      ready_q   <= 1'b0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      rcnt_q    <= rcnt_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      exp_q     <= exp_d;
      im_addr_q <= im_addr_d;
      imin_q    <= imin_d;
      wr_q      <= wr_d;
      fe_q      <= fe_d;
      rd_v_q    <= rd_v_d;
      ready_q   <= state_d == LOAD || state_d == CHECK;
      hold_q    <= state_d != DONE;
      busy_q    <= state_d == LOAD || state_d == CHECK || state_d == VERIFY;
      done_q    <= state_d == DONE;
      error_q   <= state_d == ERROR;
    end
  end
  assign in_ready     = ready_q;
  assign IM_address   = im_addr_q;
  assign enable_mem   = wr_q | fe_q;
  assign enable_write = wr_q;
  assign enable_fetch = fe_q;
  assign IMin         = imin_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed session table plus hand sequences for reset, bad length and full-depth loads.
module tb_im_loader;
  localparam int DW = 32;
  localparam int MW = 10;
  logic clk = 1'b0, reset = 1'b0, load_start = 1'b0, in_valid = 1'b0;
  logic [MW:0] load_len = '0;
  logic [DW-1:0] in_data = '0, IMout = '0, IMin;
  logic in_ready, enable_mem, enable_write, enable_fetch, cpu_hold, busy, done, error;
  logic [MW-1:0] IM_address;
  im_loader #(.DataSize(DW), .MemSize(MW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .IM_address(IM_address), .enable_mem(enable_mem), .enable_write(enable_write),
    .enable_fetch(enable_fetch), .IMin(IMin), .IMout(IMout),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error));
  always #5 clk = ~clk;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] stream [1025];
  int cyc = 0, wr_cnt = 0, fe_cnt = 0, overlap = 0, wr0_cnt = 0, last_wr_addr = 0;
  int hs[$];
  int wr_at[$];
  int checks = 0, errors = 0;
  always @(posedge clk) begin
    if (enable_write && enable_fetch) overlap++;
    if (enable_mem && enable_write) begin
      mem[IM_address] <= IMin;
      wr_cnt++;
      wr_at.push_back(cyc);
      last_wr_addr = int'(IM_address);
      if (IM_address == '0) wr0_cnt++;
    end
    if (enable_mem && enable_fetch) begin
      IMout <= mem[IM_address];
      fe_cnt++;
    end
    cyc++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_strobes"}, {29'd0, enable_mem, enable_write, enable_fetch}, 0);
    chk({tag, "_addr"}, 32'(IM_address), 0);
    chk({tag, "_imin"}, IMin, 0);
  endtask
  // Streams n data words plus the checksum from stream[], then waits for the verdict.
  task automatic run(input int n, input logic [5:0] vpat, input int plen, input bit glitch, output int lat);
    int idx, g, s, w;
    @(negedge clk);
    load_start = 1'b1;
    load_len = (MW+1)'(n);
    s = cyc + 1;
    idx = 0;
    g = 0;
    while (idx <= n && g < 4000) begin
      @(negedge clk);
      load_start = glitch && g == 1;
      load_len = '0;
      in_valid = vpat[g % plen];
      in_data = stream[idx];
      if (in_valid && in_ready) begin
        hs.push_back(cyc + 1);
        idx++;
      end
      g++;
    end
    chk("stream_accepted", 32'(idx), 32'(n + 1));
    @(negedge clk);
    in_valid = 1'b0;
    load_start = 1'b0;
    w = 0;
    while (!(done || error) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("verdict_in_time", 32'(w < 5000), 1);
    lat = cyc - s;
  endtask
  typedef struct {
    int              len;
    logic [3:0][31:0] w;
    logic [31:0]     csum;
    logic [5:0]      vpat;
    int              plen;
    bit              exp_done;
  } vec_t;
  vec_t vt [4];
  initial begin
    int lat, w0, h0, f0, base;
    vt[0] = '{4, {32'h44, 32'h33, 32'h22, 32'h11}, 32'hAA, 6'b111111, 1, 1'b1};
    vt[1] = '{4, {32'h44, 32'h33, 32'h22, 32'h11}, 32'hAB, 6'b111111, 1, 1'b0};
    vt[2] = '{3, {32'h0, 32'h10, 32'h2, 32'hFFFF_FFFF}, 32'h11, 6'b101001, 6, 1'b1};
    vt[3] = '{1, {32'h0, 32'h0, 32'h0, 32'h5}, 32'h5, 6'b111111, 1, 1'b1};
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    base = wr_cnt;
    repeat (3) @(negedge clk);
    chk("idle_valid_ignored", 32'(wr_cnt - base), 0);
    chk("idle_not_busy", {30'd0, busy, in_ready}, 0);
    in_valid = 1'b0;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vt[v].len; i++) stream[i] = vt[v].w[i];
      stream[vt[v].len] = vt[v].csum;
      w0 = wr_at.size();
      h0 = hs.size();
      f0 = fe_cnt;
      base = wr_cnt;
      run(vt[v].len, vt[v].vpat, vt[v].plen, 1'b0, lat);
      chk($sformatf("v%0d_done", v), 32'(done), 32'(vt[v].exp_done));
      chk($sformatf("v%0d_error", v), 32'(error), 32'(!vt[v].exp_done));
      chk($sformatf("v%0d_cpu_hold", v), 32'(cpu_hold), 32'(!vt[v].exp_done));
      chk($sformatf("v%0d_busy", v), 32'(busy), 0);
      chk($sformatf("v%0d_writes", v), 32'(wr_cnt - base), 32'(vt[v].len));
      chk($sformatf("v%0d_fetches", v), 32'(fe_cnt - f0), 32'(vt[v].len));
      for (int i = 0; i < vt[v].len; i++) chk($sformatf("v%0d_mem%0d", v, i), mem[i], vt[v].w[i]);
      if (wr_at.size() >= w0 + vt[v].len && hs.size() >= h0 + vt[v].len) begin
        chk($sformatf("v%0d_wr_first_timing", v), 32'(wr_at[w0]), 32'(hs[h0]));
        chk($sformatf("v%0d_wr_last_timing", v), 32'(wr_at[w0 + vt[v].len - 1]), 32'(hs[h0 + vt[v].len - 1]));
      end
      if (vt[v].plen == 1) chk($sformatf("v%0d_latency", v), 32'(lat), 32'(2 * vt[v].len + 3));
    end
    base = wr_cnt;
    f0 = fe_cnt;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      load_start = 1'b1;
      load_len = b == 0 ? 11'd0 : 11'd1025;
      @(negedge clk);
      load_start = 1'b0;
      load_len = '0;
      chk($sformatf("badlen%0d_error", b), 32'(error), 1);
      chk($sformatf("badlen%0d_done", b), 32'(done), 0);
      chk($sformatf("badlen%0d_hold", b), 32'(cpu_hold), 1);
      chk($sformatf("badlen%0d_busy", b), 32'(busy), 0);
      chk($sformatf("badlen%0d_mem_en", b), 32'(enable_mem), 0);
    end
    repeat (2) @(negedge clk);
    chk("badlen_no_strobes", 32'(wr_cnt - base + fe_cnt - f0), 0);
    for (int i = 0; i < 1024; i++) stream[i] = 32'(i);
    stream[1024] = 32'h0007_FE00;
    base = wr_cnt;
    w0 = wr0_cnt;
    run(1024, 6'b111111, 1, 1'b0, lat);
    chk("full_done", 32'(done), 1);
    chk("full_writes", 32'(wr_cnt - base), 1024);
    chk("full_last_addr", 32'(last_wr_addr), 1023);
    chk("full_addr0_once", 32'(wr0_cnt - w0), 1);
    chk("full_mem1023", mem[1023], 32'd1023);
    chk("full_latency", 32'(lat), 2051);
    @(negedge clk);
    load_start = 1'b1;
    load_len = 11'd4;
    @(negedge clk);
    load_start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h77;
    @(negedge clk);
    in_data = 32'h78;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("abort");
    base = wr_cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_more_writes", 32'(wr_cnt - base), 0);
    stream[0] = 32'd5;
    stream[1] = 32'd6;
    stream[2] = 32'd11;
    base = wr_cnt;
    run(2, 6'b111111, 1, 1'b1, lat);
    chk("restart_done", 32'(done), 1);
    chk("restart_error", 32'(error), 0);
    chk("restart_hold", 32'(cpu_hold), 0);
    chk("restart_writes", 32'(wr_cnt - base), 2);
    chk("restart_mem0", mem[0], 32'd5);
    chk("restart_mem1", mem[1], 32'd6);
    chk("restart_latency", 32'(lat), 7);
    chk("no_write_fetch_overlap", 32'(overlap), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
